// File: rtl/switch_port_rx.sv
// Switch input port: frames an in_status-qualified word stream into packets, keeps
// committed packets in a word FIFO plus descriptor queue, and replays them to the fabric.
module switch_port_rx #(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 64,
  parameter  int NUM_PORTS  = 4,
  parameter  int MAX_PKT    = 16,
  parameter  int PKT_DEPTH  = 8,
  localparam int DEST_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CNT_W      = $clog2(PKT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_status,
  output logic              in_busy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [DEST_W-1:0] out_dest,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int PW       = AW + 1;
  localparam int LEN_W    = $clog2(MAX_PKT + 1);
  localparam int QW       = (PKT_DEPTH > 1) ? $clog2(PKT_DEPTH) : 1;
  localparam int DW1      = DEST_W + 1;
  localparam int Q_LAST_I = PKT_DEPTH - 1;

  localparam logic [PW-1:0]    DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0]    MAXP_P  = PW'(MAX_PKT);
  localparam logic [LEN_W-1:0] MAXL_P  = LEN_W'(MAX_PKT);
  localparam logic [CNT_W-1:0] PKTD_P  = CNT_W'(PKT_DEPTH);
  localparam logic [DW1-1:0]   PORTS_P = DW1'(NUM_PORTS);
  localparam logic [QW-1:0]    Q_LAST  = QW'(Q_LAST_I);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} wr_state_e;

  wr_state_e         wr_state_q, wr_state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     start_ptr_q, start_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DEST_W-1:0] cur_dest_q, cur_dest_d;
  logic [QW-1:0]     desc_wr_q, desc_wr_d;
  logic [QW-1:0]     desc_rd_q, desc_rd_d;
  logic [CNT_W-1:0]  desc_cnt_q, desc_cnt_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DEST_W-1:0] out_dest_q, out_dest_d;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DEST_W-1:0] desc_dest_q [PKT_DEPTH];
  logic [LEN_W-1:0]  desc_len_q  [PKT_DEPTH];

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;
  logic              commit, drop_done, pop, xfer_last;
  logic [PW-1:0]     used, free_words;
  logic              fifo_full, pkt_full, hdr_bad;
  logic [DEST_W-1:0] hdr_dest;

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
    return (p == Q_LAST) ? '0 : p + QW'(1);
  endfunction

  // The word parked in the output register still counts as occupied until transferred.
  assign used       = wr_ptr_q - rd_ptr_q + {{(PW-1){1'b0}}, out_valid_q};
  assign free_words = DEPTH_P - used;
  assign fifo_full  = (used == DEPTH_P);
  assign pkt_full   = (pkt_cnt_q == PKTD_P);
  assign in_busy    = (free_words < MAXP_P) || pkt_full;
  assign hdr_dest   = in_data[DEST_W-1:0];
  assign hdr_bad    = ({1'b0, hdr_dest} >= PORTS_P);
  assign rd_word    = mem[rd_ptr_q[AW-1:0]];
  assign xfer_last  = out_valid_q && out_ready && out_last_q;

  // Write side: framing FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wr_state_d  = wr_state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    len_d       = len_q;
    dest_d      = dest_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q[AW-1:0];
    mem_wdata   = in_data;
    commit      = 1'b0;
    drop_done   = 1'b0;
    unique case (wr_state_q)
      S_IDLE: begin
        if (in_status) begin
          dest_d = hdr_dest;
          if (hdr_bad || fifo_full || pkt_full) begin
            wr_state_d = S_DROP;
          end else begin
            mem_we      = 1'b1;
            start_ptr_d = wr_ptr_q;
            wr_ptr_d    = wr_ptr_q + PW'(1);
            len_d       = LEN_W'(1);
            wr_state_d  = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (in_status) begin
          if ((len_q < MAXL_P) && !fifo_full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            len_d    = len_q + LEN_W'(1);
          end else begin
            // Give back the space of the partial packet; the reader never saw it.
            wr_ptr_d   = start_ptr_q;
            wr_state_d = S_DROP;
          end
        end else begin
          commit     = 1'b1;
          wr_state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (!in_status) begin
          drop_done  = 1'b1;
          wr_state_d = S_IDLE;
        end
      end
      default: wr_state_d = S_IDLE;
    endcase
  end

  // Read side: refill the output register whenever it is empty or being consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_dest_d  = out_dest_q;
    rem_d       = rem_q;
    cur_dest_d  = cur_dest_q;
    rd_ptr_d    = rd_ptr_q;
    desc_rd_d   = desc_rd_q;
    pop         = 1'b0;
    if (!out_valid_q || out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      if (rem_q != '0) begin
        out_valid_d = 1'b1;
        out_data_d  = rd_word;
        out_dest_d  = cur_dest_q;
        out_last_d  = (rem_q == LEN_W'(1));
        rem_d       = rem_q - LEN_W'(1);
        rd_ptr_d    = rd_ptr_q + PW'(1);
      end else if (desc_cnt_q != '0) begin
        pop         = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = rd_word;
        out_dest_d  = desc_dest_q[desc_rd_q];
        out_last_d  = (desc_len_q[desc_rd_q] == LEN_W'(1));
        rem_d       = desc_len_q[desc_rd_q] - LEN_W'(1);
        cur_dest_d  = desc_dest_q[desc_rd_q];
        rd_ptr_d    = rd_ptr_q + PW'(1);
        desc_rd_d   = q_inc(desc_rd_q);
      end
    end
  end

  always_comb begin
    desc_wr_d = commit ? q_inc(desc_wr_q) : desc_wr_q;
    unique case ({commit, pop})
      2'b10:   desc_cnt_d = desc_cnt_q + CNT_W'(1);
      2'b01:   desc_cnt_d = desc_cnt_q - CNT_W'(1);
      default: desc_cnt_d = desc_cnt_q;
    endcase
    unique case ({commit, xfer_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    drop_cnt_d = drop_cnt_q;
    if (drop_done && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q  <= S_IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      dest_q      <= '0;
      rem_q       <= '0;
      cur_dest_q  <= '0;
      desc_wr_q   <= '0;
      desc_rd_q   <= '0;
      desc_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_dest_q  <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      dest_q      <= dest_d;
      rem_q       <= rem_d;
      cur_dest_q  <= cur_dest_d;
      desc_wr_q   <= desc_wr_d;
      desc_rd_q   <= desc_rd_d;
      desc_cnt_q  <= desc_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_dest_q  <= out_dest_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PKT_DEPTH; i++) begin
        desc_dest_q[i] <= '0;
        desc_len_q[i]  <= '0;
      end
    end else if (commit) begin
      desc_dest_q[desc_wr_q] <= dest_q;
      desc_len_q[desc_wr_q]  <= len_q;
    end
  end

  // NOTE: the data array has no reset; pointers guarantee no slot is read before
  // it is written, so clearing it would only cost a reset network.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_dest  = out_dest_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_switch_port_rx.sv
// Directed bench for switch_port_rx: framing, backpressure, oversize and overflow drops,
// ordering, and asynchronous reset mid-packet.
module tb_switch_port_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_status = 1'b0;
  logic        in_busy;
  logic [7:0]  out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;
  logic [1:0]  out_dest;
  logic [3:0]  pkt_cnt;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;
  int max_pkt_cnt = 0;
  int base;

  logic [7:0] pkt_q[$];
  logic [7:0] cap_data[$];
  logic [1:0] cap_dest[$];
  logic       cap_last[$];
  int         cap_cyc[$];

  switch_port_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_status (in_status),
    .in_busy   (in_busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .out_dest  (out_dest),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Inputs only change 1 ns after posedge, so a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      cap_data.push_back(out_data);
      cap_dest.push_back(out_dest);
      cap_last.push_back(out_last);
      cap_cyc.push_back(cycle);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(pkt_cnt) > max_pkt_cnt) max_pkt_cnt = int'(pkt_cnt);
  endtask

  task automatic pk_clear();
    pkt_q.delete();
  endtask

  task automatic pk(input logic [7:0] w);
    pkt_q.push_back(w);
  endtask

  task automatic make_big(input int k, input logic [7:0] hdr);
    pk_clear();
    pk(hdr);
    for (int i = 1; i < 16; i++) pk(8'(k * 16 + i));
  endtask

  task automatic send_pkt();
    foreach (pkt_q[i]) begin
      in_status = 1'b1;
      in_data   = pkt_q[i];
      tick();
    end
    in_status = 1'b0;
    in_data   = '0;
    tick();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_status = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i = 0;
    while (pkt_cnt != 0 && i < budget) begin
      tick();
      i++;
    end
    check(tag, pkt_cnt, 0);
  endtask

  // Compares captured words starting at idx against pkt_q, dest and last flag.
  task automatic check_pkt(input string tag, input int idx, input logic [1:0] dest);
    int n = pkt_q.size();
    for (int i = 0; i < n; i++) begin
      if (idx + i < cap_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), cap_data[idx + i], pkt_q[i]);
        check($sformatf("%s_dest%0d", tag, i), cap_dest[idx + i], dest);
        check($sformatf("%s_last%0d", tag, i), cap_last[idx + i], (i == n - 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state and a basic 3-word packet
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_dest", out_dest, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_in_busy", in_busy, 0);
    out_ready = 1'b1;
    base = cap_data.size();
    pk_clear(); pk(8'h02); pk(8'hAA); pk(8'hBB);
    send_pkt();
    check("t1_pkt_cnt_commit", pkt_cnt, 1);
    wait_drain("t1_drain", 20);
    check("t1_words", cap_data.size() - base, 3);
    check_pkt("t1", base, 2'd2);
    check("t1_drop_cnt", drop_cnt, 0);

    // 2: stall for 5 cycles on the second word
    do_reset();
    base = cap_data.size();
    pk_clear(); pk(8'h02); pk(8'hAA); pk(8'hBB);
    send_pkt();
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check("t2_first_valid", out_valid, 1);
    check("t2_first_data", out_data, 8'h02);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2_hold_data%0d", i), out_data, 8'hAA);
      check($sformatf("t2_hold_valid%0d", i), out_valid, 1);
    end
    out_ready = 1'b1;
    wait_drain("t2_drain", 20);
    check("t2_words", cap_data.size() - base, 3);
    check_pkt("t2", base, 2'd2);

    // 3: 17-word packet is dropped, following packet delivered
    do_reset();
    out_ready = 1'b1;
    base = cap_data.size();
    pk_clear(); pk(8'h02);
    for (int i = 1; i < 17; i++) pk(8'(i));
    send_pkt();
    check("t3_drop_cnt", drop_cnt, 1);
    check("t3_pkt_cnt_after_drop", pkt_cnt, 0);
    pk_clear(); pk(8'h01); pk(8'hCC);
    send_pkt();
    wait_drain("t3_drain", 20);
    check("t3_words", cap_data.size() - base, 2);
    check_pkt("t3", base, 2'd1);
    check("t3_drop_cnt_final", drop_cnt, 1);

    // 4: fill FIFO with four 16-word packets, fifth dropped, drain in order
    do_reset();
    base = cap_data.size();
    for (int k = 0; k < 4; k++) begin
      make_big(k, 8'(k));
      send_pkt();
      if (k == 2) check("t4_busy_after3", in_busy, 0);
    end
    check("t4_busy_after4", in_busy, 1);
    check("t4_pkt_cnt4", pkt_cnt, 4);
    make_big(4, 8'h00);
    send_pkt();
    check("t4_drop_cnt", drop_cnt, 1);
    check("t4_pkt_cnt_after_drop", pkt_cnt, 4);
    out_ready = 1'b1;
    wait_drain("t4_drain", 200);
    check("t4_words", cap_data.size() - base, 64);
    for (int k = 0; k < 4; k++) begin
      make_big(k, 8'(k));
      check_pkt($sformatf("t4_p%0d", k), base + 16 * k, 2'(k));
    end
    if (cap_cyc.size() >= base + 64)
      check("t4_back_to_back", cap_cyc[base + 63] - cap_cyc[base], 63);
    check("t4_busy_drained", in_busy, 0);

    // 5: two short packets, order kept, simultaneous commit and last transfer
    do_reset();
    out_ready = 1'b1;
    max_pkt_cnt = 0;
    base = cap_data.size();
    pk_clear(); pk(8'h03); pk(8'h11);
    send_pkt();
    pk_clear(); pk(8'h00); pk(8'h22);
    send_pkt();
    check("t5_pkt_cnt_simul", pkt_cnt, 1);
    wait_drain("t5_drain", 20);
    check("t5_max_pkt_cnt_le2", (max_pkt_cnt <= 2), 1);
    check("t5_words", cap_data.size() - base, 4);
    pk_clear(); pk(8'h03); pk(8'h11);
    check_pkt("t5_a", base, 2'd3);
    pk_clear(); pk(8'h00); pk(8'h22);
    check_pkt("t5_b", base + 2, 2'd0);

    // 6: asynchronous reset in the middle of a packet
    do_reset();
    pk_clear(); pk(8'h03); pk(8'h77);
    send_pkt();
    tick();
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_pkt_cnt", pkt_cnt, 1);
    in_status = 1'b1;
    in_data   = 8'h02;
    tick();
    in_data = 8'hAA;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_data", out_data, 0);
    check("t6_async_dest", out_dest, 0);
    check("t6_async_pkt_cnt", pkt_cnt, 0);
    check("t6_async_busy", in_busy, 0);
    in_status = 1'b0;
    in_data   = '0;
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    base = cap_data.size();
    pk_clear(); pk(8'h01); pk(8'h55);
    send_pkt();
    wait_drain("t6_drain", 20);
    check("t6_words", cap_data.size() - base, 2);
    check_pkt("t6", base, 2'd1);
    check("t6_drop_cnt", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
